store_buffer: RTL
=================

# store_buffer

Parametrised store path between the MEM stage and the data-memory bus. It decodes store type and address into byte enables and lane-shifted write data, and rejects misaligned stores with a one-cycle exception pulse. Accepted stores are queued in a DEPTH-entry FIFO and drained to memory over a req/ack handshake. It also flags loads that hit a pending store, so the hazard unit can stall the load.

## Interface
- DATA_W, 32, memory bus width in bits; must be 32 or 64; NB = DATA_W/8 byte lanes, OW = log2(NB)
- ADDR_W, 32, byte address width
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- st_valid  in  1  store request from the MEM stage
- st_type  in  2  0 = none, 1 = SW (4 bytes), 2 = SH (2 bytes), 3 = SB (1 byte)
- st_addr  in  ADDR_W  byte address
- st_data  in  32  store data, right-justified (rt value)
- st_ready  out  1  store can be accepted this cycle
- st_exc  out  1  one-cycle pulse: the last offered store was misaligned
- st_badaddr  out  ADDR_W  address of the misaligned store; held until the next exception
- mem_req  out  1  head entry is valid on the mem_* outputs
- mem_ack  in  1  memory accepts the head entry
- mem_addr  out  ADDR_W  head address with low OW bits zeroed
- mem_byteen  out  NB  head byte enables
- mem_wdata  out  DATA_W  head data in lane position; non-enabled lanes are 0
- ld_addr  in  ADDR_W  address of the load in the MEM stage
- ld_hit  out  1  combinational; some valid entry has the same aligned address as ld_addr
- count  out  log2(DEPTH)+1  number of occupied entries

## Operation
- Offset off = st_addr[OW-1:0].
- Lane mapping:
  - SB → lane off.
  - SH → lanes off and off+1; requires off[0] == 0.
  - SW → lanes off through off+3; requires off[1:0] == 0.
- Shifted data = st_data[8·size−1:0] << (8·off), zero-extended to DATA_W. Only the low 8/16/32 bits of st_data are used.
- Store accepted when st_valid && st_ready && st_type != 0 && the address is aligned. The accepted store is written at the tail as {aligned addr, byteen, shifted data}.
- Misaligned offer (st_valid && st_ready && type != 0 && alignment fails):
  - Nothing is enqueued.
  - Next cycle st_exc = 1 and st_badaddr = st_addr.
- st_type == 0 with st_valid = 1: ignored, no exception.
- st_ready = !full && !reset. A full FIFO refuses a store even in a cycle where a pop occurs.
- Pop occurs when mem_req && mem_ack; the head advances.
- mem_req = !empty. All mem_* outputs come directly from the head entry register and are stable while mem_req is high and mem_ack is low.
- Simultaneous push and pop (not full): count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Full/empty come from count: count == DEPTH means full, 0 means empty.
- ld_hit compares ld_addr[ADDR_W-1:OW] against every valid entry, including the head while it is being acked. It is 0 when the FIFO is empty.
- Entries drain strictly in acceptance order. No merging.

## Timing
- Reset values: count 0, mem_req 0, st_exc 0, st_badaddr 0, ld_hit 0. mem_addr, mem_byteen and mem_wdata read as 0 while empty.
- Push to mem_req latency: 1 cycle. A store accepted at edge N is visible on mem_* after edge N when the FIFO was empty.
- Throughput: 1 store per cycle in and 1 per cycle out when mem_ack is held high.
- st_exc is asserted for exactly the one cycle after the offending offer.
- Reset asserted mid-drain: pending entries are discarded at that edge and mem_req is 0 on the following cycle, whatever mem_ack is.
- mem_ack while mem_req = 0 is ignored.

## Test plan
- DATA_W = 32, SB to 0x1003 with data 0x000000AB → mem_byteen 4'b1000, mem_wdata 0xAB000000, mem_addr 0x1000, mem_req 1 cycle after acceptance.
- DATA_W = 64:
  - SH to 0x2006 with data 0x1234 → byteen 8'b11000000, wdata 0x1234000000000000.
  - SW to 0x2004 → byteen 8'hF0.
- SW to 0x3002 → no enqueue, count stays 0, st_exc = 1 for one cycle, st_badaddr = 0x3002. SH to 0x3001 gives the same behaviour.
- DEPTH = 4, mem_ack held 0, five back-to-back SWs → first four accepted, count = 4, st_ready = 0, fifth held. Raise mem_ack for one cycle → head popped and count = 3. The fifth store is accepted on the next cycle; drain order matches push order.
- Queue SW to 0x4008 and stall memory. ld_addr = 0x400B → ld_hit = 1; ld_addr = 0x400C → ld_hit = 0. After the entry drains, ld_addr = 0x400B → ld_hit = 0.
- With 3 entries pending, assert reset for 1 cycle with mem_ack = 1 → count 0, mem_req 0, st_exc 0 on the next cycle. A new store is then accepted normally.

Source files
------------

// File: rtl/store_buffer.sv
// Store path from MEM stage to the data-memory bus: byte-lane decode, misalignment
// trap, in-order DEPTH-entry write FIFO with req/ack drain, and load-hit detection.
module store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_st_valid,
  input  logic [1:0]        i_st_type,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [31:0]       i_st_data,
  output logic              o_st_ready,
  output logic              o_st_exc,
  output logic [ADDR_W-1:0] o_st_badaddr,
  output logic              o_mem_req,
  input  logic              i_mem_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [NB-1:0]     o_mem_byteen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_ld_hit,
  output logic [CW-1:0]     o_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            r_q [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic              r_exc;
  logic [ADDR_W-1:0] r_badaddr;

  logic [OW-1:0]     w_off;
  logic [NB-1:0]     w_mask, w_be;
  logic [DATA_W-1:0] w_dat, w_wd;
  logic              w_align, w_offer, w_push, w_pop, w_bad;
  logic              w_full, w_empty, w_req;
  logic [DEPTH-1:0]  w_hit;
  entry_t            w_head;

  // Size decode: mask/data are right-justified, then shifted into lane position.
  always_comb begin
    w_off   = i_st_addr[OW-1:0];
    w_mask  = '0;
    w_dat   = '0;
    w_align = 1'b0;
    case (i_st_type)
      2'd1: begin
        w_mask  = NB'(4'hF);
        w_dat   = DATA_W'(i_st_data);
        w_align = (w_off[1:0] == 2'b00);
      end
      2'd2: begin
        w_mask  = NB'(2'h3);
        w_dat   = DATA_W'(i_st_data[15:0]);
        w_align = ~w_off[0];
      end
      2'd3: begin
        w_mask  = NB'(1'b1);
        w_dat   = DATA_W'(i_st_data[7:0]);
        w_align = 1'b1;
      end
      default: ;
    endcase
    w_be = w_mask << w_off;
    w_wd = w_dat << {w_off, 3'b000};
  end

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_req      = ~w_empty;
  assign o_st_ready = ~w_full & ~i_reset;
  assign w_offer    = i_st_valid & o_st_ready & (i_st_type != 2'd0);
  assign w_push     = w_offer & w_align;
  assign w_bad      = w_offer & ~w_align;
  assign w_pop      = w_req & i_mem_ack;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_vld     <= '0;
      r_exc     <= 1'b0;
      r_badaddr <= '0;
    end else begin
      r_exc <= w_bad;
      if (w_bad) r_badaddr <= i_st_addr;
      // Push and pop never target the same slot: that needs full or empty.
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q[r_tail].addr <= {i_st_addr[ADDR_W-1:OW], OW'(0)};
      r_q[r_tail].be   <= w_be;
      r_q[r_tail].data <= w_wd;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign w_hit[gi] = r_vld[gi] &&
                       (r_q[gi].addr[ADDR_W-1:OW] == i_ld_addr[ADDR_W-1:OW]);
  end

  assign w_head       = r_q[r_head];
  assign o_mem_req    = w_req;
  assign o_mem_addr   = w_req ? w_head.addr : '0;
  assign o_mem_byteen = w_req ? w_head.be   : '0;
  assign o_mem_wdata  = w_req ? w_head.data : '0;
  assign o_ld_hit     = |w_hit;
  assign o_count      = r_count;
  assign o_st_exc     = r_exc;
  assign o_st_badaddr = r_badaddr;

endmodule
